// File: rtl/mod_cyc_mapper.sv
// mod_cyc_mapper: streaming bit-to-phase mapper for the PUCCH/PUSCH modulation path.
// Serial coded bits are grouped into BPSK, QPSK or pi/2-BPSK symbols. For each symbol
// the block emits a registered phase index in units of 2*pi/CYC_DIV, plus a symbol index.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_start, i_mode         flush pulse; modulation latched on i_start
//                           (0 BPSK, 1 QPSK, 2 pi/2-BPSK, 3 reserved = BPSK)
//   i_bit_valid, i_bit      serial bit input
//   o_bit_ready             bit accepted when i_bit_valid && o_bit_ready
//   o_sym_valid, i_sym_ready output symbol handshake
//   o_cyc_part              phase index 0..CYC_DIV-1
//   o_sym_idx               index of the symbol on o_cyc_part, wraps modulo 2^SW
//
// Optional build macro MOD_CYC_SYM_LIMIT_EN adds i_num_sym (symbols per block, latched
// on i_start, 0 means 2^SW) and o_last (flags the final symbol). After the final
// symbol the block refuses bits until the next i_start.
module mod_cyc_mapper #(
  parameter int unsigned CYC_DIV = 24,
  parameter int unsigned PW      = 5,
  parameter int unsigned SW      = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [1:0]    i_mode,
  input  logic          i_bit_valid,
  input  logic          i_bit,
  output logic          o_bit_ready,
  output logic          o_sym_valid,
  input  logic          i_sym_ready,
  output logic [PW-1:0] o_cyc_part,
  output logic [SW-1:0] o_sym_idx
`ifdef MOD_CYC_SYM_LIMIT_EN
  ,
  input  logic [SW-1:0] i_num_sym,
  output logic          o_last
`endif
);

  typedef enum logic [1:0] {
    ModeBpsk = 2'd0,
    ModeQpsk = 2'd1,
    ModePi2  = 2'd2,
    ModeRsvd = 2'd3
  } mode_e;

  localparam logic [PW-1:0] LP_Q1  = PW'(CYC_DIV / 8);
  localparam logic [PW-1:0] LP_Q3  = PW'(3 * (CYC_DIV / 8));
  localparam logic [PW-1:0] LP_Q5  = PW'(5 * (CYC_DIV / 8));
  localparam logic [PW-1:0] LP_Q7  = PW'(7 * (CYC_DIV / 8));
  localparam logic [PW-1:0] LP_H   = PW'(CYC_DIV / 4);
  localparam logic [PW:0]   LP_DIV = (PW+1)'(CYC_DIV);

  mode_e         r_mode;
  logic          r_half;     // QPSK first bit held
  logic          r_b0;
  logic [SW-1:0] r_cnt;
  logic          r_sym_valid;
  logic [PW-1:0] r_cyc_part;
  logic [SW-1:0] r_sym_idx;

  logic          w_slot_free;
  logic          w_qpsk;
  logic          w_accept;
  logic          w_complete;
  logic          w_block_open;
  logic [PW-1:0] w_bpsk;
  logic [PW:0]   w_pi2_sum;
  logic [PW:0]   w_pi2_red;
  logic [PW-1:0] w_map;

  assign w_slot_free = !r_sym_valid || i_sym_ready;
  assign w_qpsk      = (r_mode == ModeQpsk);

`ifdef MOD_CYC_SYM_LIMIT_EN
  logic [SW-1:0] r_num_sym;
  logic          r_done;
  logic          r_last;
  logic          w_is_last;

  // i_num_sym == 0 wraps to all ones, i.e. a block of 2^SW symbols.
  assign w_is_last    = (r_cnt == (r_num_sym - SW'(1)));
  assign w_block_open = !r_done;
  assign o_last       = r_last;
`else
  assign w_block_open = 1'b1;
`endif

  // A QPSK first bit only fills the half-symbol register, so it needs no output slot.
  assign o_bit_ready = i_rst_n && !i_start && w_block_open &&
                       (w_slot_free || (w_qpsk && !r_half));
  assign w_accept    = i_bit_valid && o_bit_ready;
  assign w_complete  = w_accept && (!w_qpsk || r_half);

  always_comb begin
    w_bpsk    = i_bit ? LP_Q5 : LP_Q1;
    // Odd symbols of pi/2-BPSK are rotated by a quarter cycle.
    w_pi2_sum = {1'b0, w_bpsk} + (r_cnt[0] ? {1'b0, LP_H} : '0);
    w_pi2_red = w_pi2_sum;
    if (w_pi2_sum >= LP_DIV) begin
      w_pi2_red = w_pi2_sum - LP_DIV;
    end
    w_map = w_bpsk;
    unique case (r_mode)
      ModeQpsk: begin
        unique case ({r_b0, i_bit})
          2'b00:   w_map = LP_Q1;
          2'b01:   w_map = LP_Q7;
          2'b10:   w_map = LP_Q3;
          default: w_map = LP_Q5;
        endcase
      end
      ModePi2:  w_map = w_pi2_red[PW-1:0];
      ModeBpsk: w_map = w_bpsk;
      ModeRsvd: w_map = w_bpsk;
      default:  w_map = w_bpsk;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode      <= ModeBpsk;
      r_half      <= 1'b0;
      r_b0        <= 1'b0;
      r_cnt       <= '0;
      r_sym_valid <= 1'b0;
      r_cyc_part  <= '0;
      r_sym_idx   <= '0;
`ifdef MOD_CYC_SYM_LIMIT_EN
      r_num_sym   <= '0;
      r_done      <= 1'b0;
      r_last      <= 1'b0;
`endif
    end else if (i_start) begin
      r_mode      <= mode_e'(i_mode);
      r_half      <= 1'b0;
      r_cnt       <= '0;
      r_sym_valid <= 1'b0;
`ifdef MOD_CYC_SYM_LIMIT_EN
      r_num_sym   <= i_num_sym;
      r_done      <= 1'b0;
      r_last      <= 1'b0;
`endif
    end else begin
      if (w_accept && w_qpsk && !r_half) begin
        r_half <= 1'b1;
        r_b0   <= i_bit;
      end
      if (w_complete) begin
        r_half      <= 1'b0;
        r_sym_valid <= 1'b1;
        r_cyc_part  <= w_map;
        r_sym_idx   <= r_cnt;
        r_cnt       <= r_cnt + SW'(1);
`ifdef MOD_CYC_SYM_LIMIT_EN
        r_last      <= w_is_last;
        r_done      <= w_is_last;
`endif
      end else if (i_sym_ready) begin
        r_sym_valid <= 1'b0;
      end
    end
  end

  assign o_sym_valid = r_sym_valid;
  assign o_cyc_part  = r_cyc_part;
  assign o_sym_idx   = r_sym_idx;

endmodule

// File: tb/tb_mod_cyc_mapper.sv
module tb_mod_cyc_mapper;

  localparam int unsigned CYC_DIV = 24;
  localparam int unsigned PW      = 5;
  localparam int unsigned SW      = 12;
  localparam int          QV      = CYC_DIV / 8;
  localparam int          HV      = CYC_DIV / 4;
  localparam int          CNT_MOD = 1 << SW;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [1:0]    i_mode;
  logic          i_bit_valid;
  logic          i_bit;
  logic          o_bit_ready;
  logic          o_sym_valid;
  logic          i_sym_ready;
  logic [PW-1:0] o_cyc_part;
  logic [SW-1:0] o_sym_idx;
  logic [SW-1:0] i_num_sym;
  logic          o_last;

  always #5 clk = ~clk;

  mod_cyc_mapper #(
    .CYC_DIV (CYC_DIV),
    .PW      (PW),
    .SW      (SW)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_bit_valid (i_bit_valid),
    .i_bit       (i_bit),
    .o_bit_ready (o_bit_ready),
    .o_sym_valid (o_sym_valid),
    .i_sym_ready (i_sym_ready),
    .o_cyc_part  (o_cyc_part),
    .o_sym_idx   (o_sym_idx)
`ifdef MOD_CYC_SYM_LIMIT_EN
    ,
    .i_num_sym   (i_num_sym),
    .o_last      (o_last)
`endif
  );

`ifndef MOD_CYC_SYM_LIMIT_EN
  assign o_last = 1'b0;
`endif

  typedef struct {
    int cyc;
    int idx;
    bit last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_mode = 0;
  int m_half = 0;
  int m_b0   = 0;
  int m_cnt  = 0;
  int m_num  = CNT_MOD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_accept(input int b, output bit complete);
    exp_t e;
    int   v;
    if (m_mode == 1 && m_half == 0) begin
      m_half   = 1;
      m_b0     = b;
      complete = 1'b0;
    end else begin
      if (m_mode == 1) begin
        case (m_b0 * 2 + b)
          0:       v = QV;
          1:       v = 7 * QV;
          2:       v = 3 * QV;
          default: v = 5 * QV;
        endcase
      end else begin
        v = (b != 0) ? 5 * QV : QV;
        if (m_mode == 2 && (m_cnt % 2) == 1) v = (v + HV) % CYC_DIV;
      end
      e.cyc  = v;
      e.idx  = m_cnt;
      e.last = 1'b0;
`ifdef MOD_CYC_SYM_LIMIT_EN
      e.last = (m_cnt == m_num - 1);
`endif
      q.push_back(e);
      m_cnt    = (m_cnt + 1) % CNT_MOD;
      m_half   = 0;
      complete = 1'b1;
    end
  endtask

  // Offer one bit; leaves i_bit_valid high so consecutive calls stream one bit per cycle.
  task automatic send_bit(input int b, input bit exp_immediate);
    int n;
    bit complete;
    bit rdy;
    n           = 0;
    i_bit_valid = 1'b1;
    i_bit       = b[0];
    @(negedge clk);
    while (o_bit_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (o_bit_ready !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed o_bit_ready %b expected 1", o_bit_ready);
      @(posedge clk);
      #1;
      i_bit_valid = 1'b0;
    end else begin
      if (exp_immediate) check("ready_wait_cycles", n, 0);
      rdy = i_sym_ready;
      model_accept(b, complete);
      @(posedge clk);
      #1;
      if (rdy) check("latency_valid", o_sym_valid, complete);
    end
  endtask

  task automatic do_start(input int mode);
    i_start = 1'b1;
    i_mode  = mode[1:0];
    @(negedge clk);
    check("ready_during_start", o_bit_ready, 0);
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    i_bit_valid = 1'b0;
    check("valid_after_start", o_sym_valid, 0);
    q.delete();
    m_mode = mode;
    m_half = 0;
    m_cnt  = 0;
    m_num  = (i_num_sym == 0) ? CNT_MOD : int'(i_num_sym);
  endtask

  task automatic drain();
    int n;
    n           = 0;
    i_bit_valid = 1'b0;
    i_sym_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare at each output handshake
  always @(negedge clk) begin : mon
    exp_t e;
    if (i_rst_n === 1'b1 && o_sym_valid === 1'b1 && i_sym_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_symbol: observed cyc %0d idx %0d expected none",
               o_cyc_part, o_sym_idx);
      end else begin
        e = q.pop_front();
        check("cyc_part", o_cyc_part, e.cyc);
        check("sym_idx", o_sym_idx, e.idx);
`ifdef MOD_CYC_SYM_LIMIT_EN
        check("last", o_last, e.last);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_mode      = 2'd0;
    i_bit_valid = 1'b0;
    i_bit       = 1'b0;
    i_sym_ready = 1'b1;
    i_num_sym   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym_valid", o_sym_valid, 0);
    check("rst_cyc_part", o_cyc_part, 0);
    check("rst_sym_idx", o_sym_idx, 0);
    @(negedge clk);
    check("rst_bit_ready", o_bit_ready, 0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;

    // Reset leaves BPSK selected
    send_bit(1, 1'b1);
    drain();

    // BPSK
    do_start(0);
    send_bit(0, 1'b1); send_bit(1, 1'b1); send_bit(1, 1'b1); send_bit(0, 1'b1);
    drain();

    // QPSK
    do_start(1);
    send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(1, 1'b1);
    send_bit(1, 1'b1); send_bit(0, 1'b1); send_bit(1, 1'b1); send_bit(1, 1'b1);
    drain();

    // pi/2-BPSK, then run through the counter wrap
    do_start(2);
    send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(1, 1'b1); send_bit(1, 1'b1);
    for (int i = 0; i < CNT_MOD + 4; i++) send_bit(0, 1'b1);
    drain();

    // Reserved mode behaves as BPSK
    do_start(3);
    send_bit(1, 1'b1); send_bit(0, 1'b1);
    drain();

    // BPSK backpressure
    do_start(0);
    i_sym_ready = 1'b0;
    send_bit(1, 1'b1);
    i_bit_valid = 1'b1;
    i_bit       = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_bit_ready", o_bit_ready, 0);
      check("bp_valid", o_sym_valid, 1);
      check("bp_cyc_hold", o_cyc_part, 5 * QV);
      check("bp_idx_hold", o_sym_idx, 0);
    end
    @(posedge clk);
    #1;
    i_sym_ready = 1'b1;
    send_bit(0, 1'b1);
    drain();

    // QPSK backpressure: one first bit still accepted
    do_start(1);
    send_bit(0, 1'b1);
    i_sym_ready = 1'b0;
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    i_bit_valid = 1'b1;
    i_bit       = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("qbp_bit_ready", o_bit_ready, 0);
      check("qbp_cyc_hold", o_cyc_part, 7 * QV);
      check("qbp_idx_hold", o_sym_idx, 0);
    end
    @(posedge clk);
    #1;
    i_sym_ready = 1'b1;
    send_bit(1, 1'b1);
    drain();

    // Flush of a half QPSK symbol, bit presented during i_start
    do_start(1);
    send_bit(1, 1'b1);
    i_bit_valid = 1'b1;
    i_bit       = 1'b1;
    do_start(0);
    send_bit(1, 1'b1);
    drain();

    // Flush of a stalled output symbol
    do_start(0);
    i_sym_ready = 1'b0;
    send_bit(0, 1'b1);
    do_start(1);
    i_sym_ready = 1'b1;
    send_bit(1, 1'b1); send_bit(0, 1'b1);
    drain();

    // Reset mid-stream with a stalled symbol and a half QPSK symbol
    do_start(1);
    i_sym_ready = 1'b0;
    send_bit(1, 1'b1);
    send_bit(0, 1'b1);
    send_bit(1, 1'b1);
    i_bit_valid = 1'b0;
    i_rst_n     = 1'b0;
    @(negedge clk);
    check("midrst_bit_ready", o_bit_ready, 0);
    @(posedge clk);
    #1;
    check("midrst_valid", o_sym_valid, 0);
    check("midrst_cyc", o_cyc_part, 0);
    check("midrst_idx", o_sym_idx, 0);
    i_rst_n     = 1'b1;
    i_sym_ready = 1'b1;
    q.delete();
    m_mode = 0;
    m_half = 0;
    m_cnt  = 0;
    m_num  = CNT_MOD;
    send_bit(0, 1'b1);
    drain();

`ifdef MOD_CYC_SYM_LIMIT_EN
    // Block limit of 3 symbols
    i_num_sym = SW'(3);
    do_start(0);
    send_bit(0, 1'b1); send_bit(1, 1'b1); send_bit(1, 1'b1);
    i_bit_valid = 1'b1;
    i_bit       = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("limit_bit_ready", o_bit_ready, 0);
    end
    drain();
    i_num_sym = '0;
    do_start(0);
    send_bit(0, 1'b1);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
